// File: rtl/priority_arbiter_rr.sv
// priority_arbiter_rr: N-requester arbiter with a registered one-hot grant.
// Supports fixed priority or round-robin search, burst lock while the owner keeps
// its request, and an optional hold limit that forces a handoff when others wait.
module priority_arbiter_rr #(
    parameter int unsigned N        = 8,
    parameter int unsigned MODE     = 1,
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id
);

    localparam int unsigned IdW   = $clog2(N);
    localparam int unsigned HoldW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);
    // With MAX_HOLD = 0 the counter is tied to zero so it folds away entirely.
    localparam logic [HoldW-1:0] HoldOne = (MAX_HOLD != 0) ? HoldW'(1) : HoldW'(0);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IdW-1:0]   id_q, id_d;
    logic [IdW-1:0]   ptr_q, ptr_d;
    logic [HoldW-1:0] hold_q, hold_d;

    logic [IdW:0]     pick;
    logic [IdW-1:0]   pick_id;
    logic [IdW-1:0]   search_start;
    logic             owner_req;
    logic             expired;
    logic             take;

    // First set bit walking downward from start-1, wrapping to N-1, ending at start.
    // Returns {found, index}.
    function automatic logic [IdW:0] find_first(input logic [N-1:0]   vec,
                                                input logic [IdW-1:0] start);
        logic [IdW:0] res;
        int unsigned  idx;
        res = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = 32'(start) + N - k;
            if (idx >= N) idx = idx - N;
            if (!res[IdW] && vec[IdW'(idx)]) res = {1'b1, IdW'(idx)};
        end
        return res;
    endfunction

    // Next-state: arbitration, burst lock, hold limit and release to idle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        take    = 1'b0;

        // Fixed priority is round-robin with the pointer pinned at 0.
        search_start = (MODE != 0) ? ptr_q : '0;
        // Masking the owner is harmless on release (its bit is already low) and
        // is exactly what expiry needs, so a single search covers both.
        pick      = find_first(req & ~grant_q, search_start);
        pick_id   = pick[IdW-1:0];
        owner_req = req[id_q];
        expired   = (MAX_HOLD != 0) && (hold_q == HoldMax);

        unique case (state_q)
            StIdle: begin
                if (pick[IdW]) take = 1'b1;
            end
            StBusy: begin
                if (owner_req && !expired) begin
                    if (hold_q != HoldMax) hold_d = hold_q + HoldW'(1);
                end else if (pick[IdW]) begin
                    take = 1'b1;
                end else if (owner_req) begin
                    // Expired but nobody else waiting: keep the grant, restart count.
                    hold_d = HoldOne;
                end else begin
                    state_d = StIdle;
                    grant_d = '0;
                    id_d    = '0;
                    hold_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (take) begin
            state_d          = StBusy;
            grant_d          = '0;
            grant_d[pick_id] = 1'b1;
            id_d             = pick_id;
            ptr_d            = pick_id;
            hold_d           = HoldOne;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_id    = id_q;

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Testbench for priority_arbiter_rr: four instances (fixed priority, round-robin,
// round-robin with hold limits 4 and 2) share clock, reset and request stimulus.
module tb_priority_arbiter_rr;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;

    logic [7:0] g0, g1, g2, g3;
    logic       v0, v1, v2, v3;
    logic [2:0] i0, i1, i2, i3;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        int         sel;
        logic [7:0] eg;
        logic [2:0] eid;
    } vec_t;

    vec_t vecs[$];

    priority_arbiter_rr #(.N(8), .MODE(0), .MAX_HOLD(0)) u_m0 (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(g0), .grant_valid(v0), .grant_id(i0)
    );
    priority_arbiter_rr #(.N(8), .MODE(1), .MAX_HOLD(0)) u_m1 (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(g1), .grant_valid(v1), .grant_id(i1)
    );
    priority_arbiter_rr #(.N(8), .MODE(1), .MAX_HOLD(4)) u_h4 (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(g2), .grant_valid(v2), .grant_id(i2)
    );
    priority_arbiter_rr #(.N(8), .MODE(1), .MAX_HOLD(2)) u_h2 (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(g3), .grant_valid(v3), .grant_id(i3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int sel, input logic [7:0] eg,
                         input logic [2:0] eid);
        logic [7:0] g;
        logic       v;
        logic [2:0] id;
        case (sel)
            0:       begin g = g0; v = v0; id = i0; end
            1:       begin g = g1; v = v1; id = i1; end
            2:       begin g = g2; v = v2; id = i2; end
            default: begin g = g3; v = v3; id = i3; end
        endcase
        n_run++;
        if (g !== eg || v !== (eg != 8'h00) || id !== eid) begin
            n_fail++;
            $display("FAIL %s: got grant=%h valid=%b id=%0d, want grant=%h valid=%b id=%0d",
                     name, g, v, id, eg, (eg != 8'h00), eid);
        end
    endtask

    task automatic add(input logic r, input logic [7:0] rq, input int s,
                       input logic [7:0] eg, input logic [2:0] eid, input int reps);
        vec_t v;
        v.rst_n = r;
        v.req   = rq;
        v.sel   = s;
        v.eg    = eg;
        v.eid   = eid;
        for (int i = 0; i < reps; i++) vecs.push_back(v);
    endtask

    initial begin
        logic [2:0] exp_id;
        logic [7:0] own;
        int         nid;

        rst_n = 1'b0;
        req   = 8'h00;

        // T1: reset holds outputs low with all requesting; first grant to 7 (fixed prio)
        add(1'b0, 8'hFF, 0, 8'h00, 3'd0, 2);
        add(1'b1, 8'hFF, 0, 8'h80, 3'd7, 1);
        // T2: fixed priority burst lock, gapless handoff, idle, lock ignores others
        add(1'b0, 8'h00, 0, 8'h00, 3'd0, 1);
        add(1'b1, 8'h81, 0, 8'h80, 3'd7, 5);
        add(1'b1, 8'h01, 0, 8'h01, 3'd0, 2);
        add(1'b1, 8'h00, 0, 8'h00, 3'd0, 1);
        add(1'b1, 8'h06, 0, 8'h04, 3'd2, 1);
        add(1'b1, 8'h86, 0, 8'h04, 3'd2, 1);
        add(1'b1, 8'h82, 0, 8'h80, 3'd7, 1);
        add(1'b1, 8'h00, 0, 8'h00, 3'd0, 1);
        // T4: hold limit 4 alternates between two steady requesters
        add(1'b0, 8'h00, 2, 8'h00, 3'd0, 1);
        add(1'b1, 8'h0C, 2, 8'h08, 3'd3, 4);
        add(1'b1, 8'h0C, 2, 8'h04, 3'd2, 4);
        add(1'b1, 8'h0C, 2, 8'h08, 3'd3, 4);
        // Unlimited hold never hands off while the owner requests
        add(1'b0, 8'h00, 1, 8'h00, 3'd0, 1);
        add(1'b1, 8'h0C, 1, 8'h08, 3'd3, 10);
        // T5: hold limit 2 with a lone requester keeps the grant continuously
        add(1'b0, 8'h00, 3, 8'h00, 3'd0, 1);
        add(1'b1, 8'h10, 3, 8'h10, 3'd4, 6);

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            req   = vecs[i].req;
            tick();
            check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].eg, vecs[i].eid);
        end

        // T3: round-robin rotation, each owner drops its request for one cycle
        rst_n = 1'b0;
        req   = 8'h00;
        tick();
        rst_n = 1'b1;
        req   = 8'hFF;
        tick();
        check("t3_rot0", 1, 8'h80, 3'd7);
        exp_id = 3'd7;
        for (int i = 1; i <= 8; i++) begin
            own = 8'h01 << exp_id;
            req = 8'hFF & ~own;
            tick();
            nid    = (15 - i) % 8;
            exp_id = 3'(nid);
            check($sformatf("t3_rot%0d", i), 1, 8'h01 << nid, exp_id);
        end

        // T6: release to idle, then reset mid-burst
        rst_n = 1'b0;
        req   = 8'h00;
        tick();
        rst_n = 1'b1;
        req   = 8'h02;
        tick();
        check("t6_grant1", 1, 8'h02, 3'd1);
        req = 8'h00;
        tick();
        check("t6_idle", 1, 8'h00, 3'd0);
        req = 8'h08;
        tick();
        check("t6_grant3", 1, 8'h08, 3'd3);
        req = 8'h18;
        tick();
        check("t6_lock3", 1, 8'h08, 3'd3);
        rst_n = 1'b0;
        tick();
        check("t6_rst_mid", 1, 8'h00, 3'd0);
        rst_n = 1'b1;
        tick();
        check("t6_after_rst", 1, 8'h10, 3'd4);

        // Pointer must return to 0 on reset: 0x0A from ptr 0 picks 3, from ptr 3 picks 1
        req = 8'h08;
        tick();
        check("t6_ptr3", 1, 8'h08, 3'd3);
        rst_n = 1'b0;
        req   = 8'h0A;
        tick();
        check("t6_rst_ptr", 1, 8'h00, 3'd0);
        rst_n = 1'b1;
        tick();
        check("t6_ptr_zero", 1, 8'h08, 3'd3);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
